// File: rtl/fetch_sequencer.sv
// Fetch-control FSM: sequences PC load, memory wait, instruction latch, decoder
// issue and optional jump-register load, with halt at instruction boundaries.
module fetch_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 START,
    input  logic                 HALT,
    input  logic                 PC_SRC_VALID,
    input  logic                 PC_SRC_SEL,
    input  logic                 JUMP_REQ,
    input  logic                 DEC_READY,
    output logic                 CTRL_REG_PC,
    output logic                 CTRL_REG_INSTR,
    output logic                 CTRL_REG_ARG,
    output logic                 CTRL_REG_JUMP,
    output logic                 SEL_MUX,
    output logic                 INSTR_VALID,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] FETCH_COUNT
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LATENCY - 1);

    // Elaboration-time parameter legality checks.
    if (MEM_LATENCY == 0 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("fetch_sequencer: MEM_LATENCY must be 1..15");
    end
    if (ADDR_WIDTH == 0 || CNT_WIDTH == 0) begin : g_bad_width
        $error("fetch_sequencer: ADDR_WIDTH and CNT_WIDTH must be nonzero");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PC   = 3'd1,
        MEM_WAIT  = 3'd2,
        LATCH     = 3'd3,
        ISSUE     = 3'd4,
        JUMP_LOAD = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  halt_q, halt_d;
    logic [CNT_WIDTH-1:0]  count_d;
    logic                  halt_now;

    // State, wait counter, sticky halt and fetch counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            halt_q      <= 1'b0;
            FETCH_COUNT <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            halt_q      <= halt_d;
            FETCH_COUNT <= count_d;
        end
    end

    // Next-state logic; a halt seen this cycle counts as already pending.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        halt_d   = halt_q;
        count_d  = FETCH_COUNT;
        halt_now = halt_q | HALT;
        case (state_q)
            IDLE: begin
                if (START && !HALT) state_d = WAIT_PC;
            end
            WAIT_PC: begin
                if (PC_SRC_VALID) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_LOAD;
                end
            end
            MEM_WAIT: begin
                if (wait_q == '0) state_d = LATCH;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            LATCH: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                if (DEC_READY) begin
                    count_d = FETCH_COUNT + CNT_WIDTH'(1);
                    if (JUMP_REQ)      state_d = JUMP_LOAD;
                    else if (halt_now) state_d = IDLE;
                    else               state_d = WAIT_PC;
                end
            end
            JUMP_LOAD: begin
                state_d = halt_now ? IDLE : WAIT_PC;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_q != IDLE) halt_d = halt_now;
        if (state_d == IDLE) halt_d = 1'b0;
    end

    // Datapath enables decoded from state; PC load follows the source handshake.
    always_comb begin
        CTRL_REG_PC    = 1'b0;
        CTRL_REG_INSTR = 1'b0;
        CTRL_REG_ARG   = 1'b0;
        CTRL_REG_JUMP  = 1'b0;
        SEL_MUX        = 1'b0;
        INSTR_VALID    = 1'b0;
        BUSY           = (state_q != IDLE);
        case (state_q)
            WAIT_PC: begin
                CTRL_REG_PC = PC_SRC_VALID;
                SEL_MUX     = PC_SRC_VALID & PC_SRC_SEL;
            end
            LATCH: begin
                CTRL_REG_INSTR = 1'b1;
                CTRL_REG_ARG   = 1'b1;
            end
            ISSUE: begin
                INSTR_VALID = 1'b1;
            end
            JUMP_LOAD: begin
                CTRL_REG_JUMP = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (latency 1 / 4-bit count, latency 3 /
// 16-bit count) driven in lockstep, checked against a position-based fetch model.
module tb_fetch_sequencer;

    localparam int L0 = 1;
    localparam int C0 = 4;
    localparam int L1 = 3;
    localparam int C1 = 16;

    logic clk = 1'b0;
    logic rst, start, halt, valid, sel, jump, dec;

    logic pc0, in0, ar0, jp0, sm0, iv0, bz0;
    logic pc1, in1, ar1, jp1, sm1, iv1, bz1;
    logic [C0-1:0] fc0;
    logic [C1-1:0] fc1;
    logic [6:0] o0, o1;

    assign o0 = {pc0, in0, ar0, jp0, sm0, iv0, bz0};
    assign o1 = {pc1, in1, ar1, jp1, sm1, iv1, bz1};

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_WIDTH(12), .MEM_LATENCY(L0), .CNT_WIDTH(C0)) u_dut0 (
        .clk(clk), .rst(rst), .START(start), .HALT(halt), .PC_SRC_VALID(valid),
        .PC_SRC_SEL(sel), .JUMP_REQ(jump), .DEC_READY(dec),
        .CTRL_REG_PC(pc0), .CTRL_REG_INSTR(in0), .CTRL_REG_ARG(ar0),
        .CTRL_REG_JUMP(jp0), .SEL_MUX(sm0), .INSTR_VALID(iv0), .BUSY(bz0),
        .FETCH_COUNT(fc0));

    fetch_sequencer #(.ADDR_WIDTH(10), .MEM_LATENCY(L1), .CNT_WIDTH(C1)) u_dut1 (
        .clk(clk), .rst(rst), .START(start), .HALT(halt), .PC_SRC_VALID(valid),
        .PC_SRC_SEL(sel), .JUMP_REQ(jump), .DEC_READY(dec),
        .CTRL_REG_PC(pc1), .CTRL_REG_INSTR(in1), .CTRL_REG_ARG(ar1),
        .CTRL_REG_JUMP(jp1), .SEL_MUX(sm1), .INSTR_VALID(iv1), .BUSY(bz1),
        .FETCH_COUNT(fc1));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: pos 0 = awaiting PC, 1..L = memory wait, L+1 latch, L+2 issue, L+3 jump.
    bit act [2] = '{0, 0};
    int pos [2] = '{0, 0};
    bit hp  [2] = '{0, 0};
    int cnt [2] = '{0, 0};
    int lat [2] = '{L0, L1};
    int cw  [2] = '{C0, C1};

    logic [6:0] snap0, snap1;
    int sfc0, sfc1;
    int last_iv [2] = '{-1, -1};
    int gap [2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] exp_out(input int i);
        logic [6:0] e;
        e = '0;
        if (act[i]) begin
            e[0] = 1'b1;
            if (pos[i] == 0) begin
                e[6] = valid;
                e[2] = valid & sel;
            end else if (pos[i] == lat[i] + 1) begin
                e[5] = 1'b1;
                e[4] = 1'b1;
            end else if (pos[i] == lat[i] + 2) begin
                e[1] = 1'b1;
            end else if (pos[i] == lat[i] + 3) begin
                e[3] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic model_step(input int i);
        bit h;
        if (rst) begin
            act[i] = 0; hp[i] = 0; cnt[i] = 0; pos[i] = 0;
        end else if (!act[i]) begin
            if (start && !halt) begin act[i] = 1; pos[i] = 0; end
        end else begin
            h = hp[i] || halt;
            hp[i] = h;
            if (pos[i] == 0) begin
                if (valid) pos[i] = 1;
            end else if (pos[i] <= lat[i] + 1) begin
                pos[i]++;
            end else if (pos[i] == lat[i] + 2) begin
                if (dec) begin
                    cnt[i] = (cnt[i] + 1) & ((1 << cw[i]) - 1);
                    if (jump)   pos[i] = lat[i] + 3;
                    else if (h) begin act[i] = 0; hp[i] = 0; end
                    else        pos[i] = 0;
                end
            end else begin
                if (h) begin act[i] = 0; hp[i] = 0; end
                else   pos[i] = 0;
            end
        end
    endtask

    // One clock: compare mid-cycle, then advance the model on the rising edge.
    task automatic step();
        @(negedge clk);
        chk("dut0 outputs", 32'(o0), 32'(exp_out(0)));
        chk("dut0 count", 32'(fc0), 32'(cnt[0]));
        chk("dut1 outputs", 32'(o1), 32'(exp_out(1)));
        chk("dut1 count", 32'(fc1), 32'(cnt[1]));
        snap0 = o0; snap1 = o1; sfc0 = int'(fc0); sfc1 = int'(fc1);
        if (o0[1]) begin if (last_iv[0] >= 0) gap[0] = cyc - last_iv[0]; last_iv[0] = cyc; end
        if (o1[1]) begin if (last_iv[1] >= 0) gap[1] = cyc - last_iv[1]; last_iv[1] = cyc; end
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
    endtask

    task automatic set_in(input logic s, input logic h, input logic v, input logic sl,
                          input logic j, input logic d);
        start = s; halt = h; valid = v; sel = sl; jump = j; dec = d;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int n, cntv;
    bit found;

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        chk("reset busy", 32'(snap0[0]), 32'd0);
        chk("reset outputs", 32'(snap0), 32'd0);
        chk("reset count", 32'(sfc0), 32'd0);

        // Back-to-back fetch, latency 1: PC, wait, latch, issue, 4-cycle spacing.
        set_in(1, 0, 1, 0, 0, 1);
        step();
        start = 1'b0;
        step();
        chk("pc load after start", 32'(snap0[6]), 32'd1);
        chk("sel_mux alu source", 32'(snap0[2]), 32'd0);
        step();
        step();
        chk("latch enables", 32'(snap0[5:4]), 32'd3);
        step();
        chk("instr valid", 32'(snap0[1]), 32'd1);
        step();
        chk("count after first issue", 32'(sfc0), 32'd1);
        for (int k = 0; k < 16; k++) step();
        chk("issue spacing lat1", 32'(gap[0]), 32'd4);
        chk("issue spacing lat3", 32'(gap[1]), 32'd6);

        // Function-stack source: SEL_MUX only together with the PC load.
        sel = 1'b1;
        cntv = 0; n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (snap0[2] != snap0[6]) n++;
            if (snap0[2]) cntv++;
        end
        chk("sel_mux outside pc load", 32'(n), 32'd0);
        chk("sel_mux seen", 32'(cntv > 0), 32'd1);

        // Decoder stall: five not-ready cycles then the handshake.
        do_reset();
        set_in(1, 0, 1, 0, 0, 0);
        step();
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (snap0[1]) found = 1;
        end
        chk("reached issue", 32'(found), 32'd1);
        n = sfc0; cntv = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (snap0[1]) cntv++;
            chk("no enables while stalled", 32'(snap0[6:3]), 32'd0);
        end
        valid = 1'b0;
        dec = 1'b1;
        step();
        if (snap0[1]) cntv++;
        dec = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (snap0[1]) cntv++;
        end
        chk("instr valid stall cycles", 32'(cntv), 32'd6);
        chk("stall count once", 32'(sfc0 - n), 32'd1);

        // Jump with halt raised during the memory wait.
        do_reset();
        set_in(1, 0, 1, 0, 1, 1);
        step();
        start = 1'b0;
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        step();
        chk("handshake with jump", 32'(snap0[1]), 32'd1);
        step();
        chk("jump load", 32'(snap0[3]), 32'd1);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (snap0[0] || snap0[6]) n++;
        end
        chk("idle after halt", 32'(n), 32'd0);

        // Reset mid-fetch, then a clean restart.
        do_reset();
        set_in(1, 0, 1, 0, 0, 1);
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("outputs after mid reset", 32'(snap0), 32'd0);
        chk("count after mid reset", 32'(sfc0), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("restart pc load", 32'(snap0[6]), 32'd1);

        // Counter wrap on the 4-bit instance after 16 handshakes.
        do_reset();
        set_in(1, 0, 1, 0, 0, 1);
        step();
        start = 1'b0;
        n = 0;
        for (int k = 0; k < 200 && n < 16; k++) begin
            step();
            if (snap0[1]) n++;
        end
        chk("sixteen handshakes", 32'(n), 32'd16);
        step();
        chk("count wrap", 32'(sfc0), 32'd0);

        // START and HALT together in IDLE: stays idle.
        do_reset();
        set_in(1, 1, 1, 0, 0, 1);
        step();
        set_in(0, 0, 1, 0, 0, 1);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (snap0[0] || snap1[0]) n++;
        end
        chk("start with halt ignored", 32'(n), 32'd0);

        // Randomised traffic against the model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 7) == 0);
            halt  = ($urandom_range(0, 15) == 0);
            valid = 1'($urandom_range(0, 1));
            sel   = 1'($urandom_range(0, 1));
            jump  = ($urandom_range(0, 3) == 0);
            dec   = 1'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
